cache_req_if: RTL and testbench
===============================

CACHE_REQ_IF -- requirements
Module: cache_req_if

Interface
REQ-001 Parameter KEY_WIDTH, default 32: key width in bits.
REQ-002 Parameter VALUE_WIDTH, default 64: value width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, legal range 1..1023: maximum WAIT cycles before abort.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_op  in  operation_e  requested operation (NOOP/READ/UPSERT/DELETE, ctrl_types_pkg).
REQ-009 req_key  in  KEY_WIDTH  request key.
REQ-010 req_value  in  VALUE_WIDTH  upsert payload.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  host accepts the response.
REQ-013 resp_hit  out  1  READ found the key.
REQ-014 resp_value  out  VALUE_WIDTH  READ data.
REQ-015 resp_err  out  1  operation ended in controller error or timeout.
REQ-016 resp_timeout  out  1  operation aborted by the timeout.
REQ-017 operation_out  out  operation_e  command to the cache controller.
REQ-018 busy_in  in  1  controller busy flag.
REQ-019 busy_valid_in  in  1  busy_in is valid.
REQ-020 hit_in  in  1  controller hit flag.
REQ-021 hit_valid_in  in  1  hit_in is valid.
REQ-022 operation_valid_in  in  1  controller reports successful completion.
REQ-023 data_valid_in  in  1  value_in is valid.
REQ-024 key_out  out  KEY_WIDTH  key to the memory array.
REQ-025 value_out  out  VALUE_WIDTH  write data to the memory array.
REQ-026 value_in  in  VALUE_WIDTH  read data from the memory array.

Function
REQ-027 FSM states IDLE, ISSUE, WAIT, RESP; all outputs are registered or decoded from state only, with no combinational path from any input to any output.
REQ-028 IDLE: req_ready=1; a request is accepted on a cycle with req_valid&&req_ready; req_op, req_key and req_value are captured into registers.
REQ-029 Accept with req_op=NOOP: next state RESP with hit/err/timeout=0 and resp_value=0; no command is issued.
REQ-030 Accept with req_op other than NOOP: next state ISSUE; the timeout counter clears to 0.
REQ-031 ISSUE lasts exactly 1 cycle and operation_out equals the captured op; in every other state operation_out=NOOP, so the controller never re-launches the command.
REQ-032 key_out and value_out show the captured registers and hold stable from ISSUE until the next accept.
REQ-033 WAIT success: on a cycle with busy_valid_in=1, busy_in=0 and operation_valid_in=1, go to RESP with err=0; resp_hit = (op==READ)&&hit_valid_in&&hit_in; resp_value = value_in if (op==READ)&&data_valid_in&&hit_in, else 0.
REQ-034 WAIT error: on a cycle with busy_valid_in=1, busy_in=0 and operation_valid_in=0, go to RESP with resp_err=1, resp_hit=0 and resp_value=0.
REQ-035 Cycles with busy_valid_in=1 and busy_in=1 are ignored in WAIT.
REQ-036 The timeout counter increments once per WAIT cycle, saturates, and uses width clog2(TIMEOUT_CYCLES+1).
REQ-037 If no completion arrives and the counter reaches TIMEOUT_CYCLES: go to RESP with resp_err=1, resp_timeout=1, hit=0, value=0.
REQ-038 Completion and timeout in the same cycle: completion wins.
REQ-039 RESP: resp_valid=1 and all resp_* fields hold stable until resp_ready=1, then next state IDLE.
REQ-040 Back-to-back requests: the minimum accept-to-accept spacing is 4 cycles (IDLE, ISSUE, at least one WAIT cycle, RESP); req_ready=0 in every state except IDLE.

Reset
REQ-041 While rst_n=0, at any point including mid-operation:
- state=IDLE
- req_ready=1
- resp_valid, resp_hit, resp_err, resp_timeout = 0
- resp_value, key_out, value_out = 0
- operation_out=NOOP
- timeout counter = 0
- any in-flight request is discarded with no response.

Verification
REQ-042 READ key 0x5, controller signals done after 3 WAIT cycles with hit_in=1, data_valid_in=1, value_in=0xDEAD -> operation_out=READ for exactly 1 cycle; resp_valid with hit=1, value=0xDEAD, err=0.
REQ-043 UPSERT key 0x7 / value 0x1234 -> key_out=0x7 and value_out=0x1234 stable through WAIT; response hit=0, err=0.
REQ-044 DELETE with the controller entering its error state (busy_valid_in=1, busy_in=0, operation_valid_in=0) -> resp_err=1, resp_timeout=0.
REQ-045 TIMEOUT_CYCLES=4, controller silent -> response after exactly 4 WAIT cycles with err=1, timeout=1; completion on the 4th cycle -> err=0.
REQ-046 resp_ready held low 5 cycles -> resp_* stable, req_ready=0, and a new req_valid is not accepted until the cycle after the handshake.
REQ-047 rst_n asserted during WAIT -> all outputs at reset values immediately, no response; a fresh READ afterwards completes normally.

Source files
------------

// File: rtl/cache_req_if.sv
// Host-side request interface for the cache controller: accepts one request,
// issues it for a single cycle, waits for completion or timeout, then holds the response.
package ctrl_types_pkg;
  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;
endpackage

module cache_req_if
  import ctrl_types_pkg::*;
#(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  operation_e             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic                   resp_err,
  output logic                   resp_timeout,
  output operation_e             operation_out,
  input  logic                   busy_in,
  input  logic                   busy_valid_in,
  input  logic                   hit_in,
  input  logic                   hit_valid_in,
  input  logic                   operation_valid_in,
  input  logic                   data_valid_in,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  input  logic [VALUE_WIDTH-1:0] value_in
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  operation_e             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   hit_q, hit_d;
  logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
  logic                   err_q, err_d;
  logic                   tmo_q, tmo_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             ctrl_settled;
  logic             timed_out;
  logic             is_read;

  // The counter value after this WAIT cycle; timeout fires on the cycle it reaches the limit
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timed_out    = (cnt_inc == CNT_MAX);
  assign ctrl_settled = busy_valid_in && !busy_in;
  assign is_read      = (op_q == READ);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    value_d  = value_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    rvalue_d = rvalue_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          key_d   = req_key;
          value_d = req_value;
          cnt_d   = '0;
          if (req_op == NOOP) begin
            state_d  = RESP;
            hit_d    = 1'b0;
            rvalue_d = '0;
            err_d    = 1'b0;
            tmo_d    = 1'b0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_inc;
        // A settled controller wins over a timeout landing in the same cycle
        if (ctrl_settled) begin
          state_d = RESP;
          tmo_d   = 1'b0;
          if (operation_valid_in) begin
            hit_d    = is_read && hit_valid_in && hit_in;
            rvalue_d = (is_read && data_valid_in && hit_in) ? value_in : '0;
            err_d    = 1'b0;
          end else begin
            hit_d    = 1'b0;
            rvalue_d = '0;
            err_d    = 1'b1;
          end
        end else if (timed_out) begin
          state_d  = RESP;
          hit_d    = 1'b0;
          rvalue_d = '0;
          err_d    = 1'b1;
          tmo_d    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= NOOP;
      key_q    <= '0;
      value_q  <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      rvalue_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      value_q  <= value_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      rvalue_q <= rvalue_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // The command is visible only in ISSUE so the controller launches it exactly once
  assign operation_out = (state_q == ISSUE) ? op_q : NOOP;
  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_hit      = hit_q;
  assign resp_value    = rvalue_q;
  assign resp_err      = err_q;
  assign resp_timeout  = tmo_q;
  assign key_out       = key_q;
  assign value_out     = value_q;

endmodule

// File: tb/tb_cache_req_if.sv
// Directed bench for cache_req_if: a vector table of complete transactions
// plus hand-written sequences for response back-pressure and mid-operation reset.
module tb_cache_req_if;
  import ctrl_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  operation_e  req_op = NOOP;
  logic [31:0] req_key = '0;
  logic [63:0] req_value = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit;
  logic [63:0] resp_value;
  logic        resp_err;
  logic        resp_timeout;
  operation_e  operation_out;
  logic        busy_in = 1'b0;
  logic        busy_valid_in = 1'b0;
  logic        hit_in = 1'b0;
  logic        hit_valid_in = 1'b0;
  logic        operation_valid_in = 1'b0;
  logic        data_valid_in = 1'b0;
  logic [31:0] key_out;
  logic [63:0] value_out;
  logic [63:0] value_in = '0;

  int n_vec = 0;
  int n_err = 0;

  cache_req_if #(.KEY_WIDTH(32), .VALUE_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_value(resp_value), .resp_err(resp_err), .resp_timeout(resp_timeout),
    .operation_out(operation_out),
    .busy_in(busy_in), .busy_valid_in(busy_valid_in),
    .hit_in(hit_in), .hit_valid_in(hit_valid_in),
    .operation_valid_in(operation_valid_in), .data_valid_in(data_valid_in),
    .key_out(key_out), .value_out(value_out), .value_in(value_in)
  );

  always #5 clk = ~clk;

  // ev_cycle is the WAIT cycle on which the controller settles; 0 means never
  typedef struct {
    operation_e  op;
    logic [31:0] key;
    logic [63:0] value;
    int          ev_cycle;
    logic        ev_done;
    logic        hv;
    logic        hit;
    logic        dv;
    logic [63:0] rd;
    logic        exp_hit;
    logic [63:0] exp_value;
    logic        exp_err;
    logic        exp_to;
    int          exp_waits;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    busy_in = 1'b0; busy_valid_in = 1'b0; hit_in = 1'b0; hit_valid_in = 1'b0;
    operation_valid_in = 1'b0; data_valid_in = 1'b0; value_in = '0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first WAIT cycle (or RESP for NOOP)
  task automatic do_accept(input operation_e op, input logic [31:0] key, input logic [63:0] value);
    req_valid = 1'b1; req_op = op; req_key = key; req_value = value;
    @(negedge clk);
    req_valid = 1'b0;
    if (op != NOOP) begin
      check_output("issue_op", 64'(operation_out), 64'(op));
      check_output("issue_req_ready", 64'(req_ready), 64'd0);
      check_output("issue_key", 64'(key_out), 64'(key));
      check_output("issue_value", value_out, value);
      @(negedge clk);
      check_output("wait_op_noop", 64'(operation_out), 64'(NOOP));
    end
  endtask

  task automatic run_wait(input vec_t v, output int waits);
    waits = 0;
    while (!resp_valid && waits < 40) begin
      waits++;
      busy_valid_in = 1'b1;
      if (waits == v.ev_cycle) begin
        busy_in = 1'b0; operation_valid_in = v.ev_done;
        hit_valid_in = v.hv; hit_in = v.hit; data_valid_in = v.dv; value_in = v.rd;
      end else begin
        busy_in = 1'b1; operation_valid_in = 1'b1; hit_valid_in = 1'b1; hit_in = 1'b1;
      end
      @(negedge clk);
      clear_ctrl();
      if (!resp_valid) begin
        check_output("wait_key_hold", 64'(key_out), 64'(v.key));
        check_output("wait_value_hold", value_out, v.value);
      end
    end
  endtask

  task automatic check_resp(input vec_t v);
    check_output("resp_valid", 64'(resp_valid), 64'd1);
    check_output("resp_hit", 64'(resp_hit), 64'(v.exp_hit));
    check_output("resp_value", resp_value, v.exp_value);
    check_output("resp_err", 64'(resp_err), 64'(v.exp_err));
    check_output("resp_timeout", 64'(resp_timeout), 64'(v.exp_to));
    check_output("resp_req_ready", 64'(req_ready), 64'd0);
    check_output("resp_op_noop", 64'(operation_out), 64'(NOOP));
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("post_hs_resp_valid", 64'(resp_valid), 64'd0);
    check_output("post_hs_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    int waits;
    check_output("idle_req_ready", 64'(req_ready), 64'd1);
    do_accept(v.op, v.key, v.value);
    run_wait(v, waits);
    check_output("wait_cycles", 64'(waits), 64'(v.exp_waits));
    check_resp(v);
    handshake();
  endtask

  initial begin
    vec_t v;
    int   waits;

    //          op      key    value      ev dn hv ht dv rd          ehit evalue     eerr eto waits
    vecs[0] = '{READ,   32'h5, 64'h0,     3, 1, 1, 1, 1, 64'hDEAD,   1, 64'hDEAD,   0, 0, 3};
    vecs[1] = '{UPSERT, 32'h7, 64'h1234,  2, 1, 1, 1, 1, 64'hBEEF,   0, 64'h0,      0, 0, 2};
    vecs[2] = '{DELETE, 32'h9, 64'h0,     1, 0, 0, 0, 0, 64'h0,      0, 64'h0,      1, 0, 1};
    vecs[3] = '{READ,   32'hA, 64'h0,     0, 0, 0, 0, 0, 64'h0,      0, 64'h0,      1, 1, 4};
    vecs[4] = '{READ,   32'hB, 64'h0,     4, 1, 1, 1, 1, 64'hCAFE,   1, 64'hCAFE,   0, 0, 4};
    vecs[5] = '{READ,   32'hC, 64'h0,     1, 1, 1, 0, 1, 64'h55,     0, 64'h0,      0, 0, 1};
    vecs[6] = '{READ,   32'hD, 64'h0,     2, 1, 1, 1, 0, 64'h77,     1, 64'h0,      0, 0, 2};
    vecs[7] = '{READ,   32'hE, 64'h0,     1, 1, 0, 1, 1, 64'h99,     0, 64'h99,     0, 0, 1};
    vecs[8] = '{NOOP,   32'h3, 64'h66,    0, 0, 0, 0, 0, 64'h0,      0, 64'h0,      0, 0, 0};
    vecs[9] = '{READ,   32'hF, 64'h0,     3, 0, 1, 1, 1, 64'h1111,   0, 64'h0,      1, 0, 3};

    repeat (2) @(negedge clk);
    check_output("rst_req_ready", 64'(req_ready), 64'd1);
    check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_output("rst_op", 64'(operation_out), 64'(NOOP));
    check_output("rst_key_out", 64'(key_out), 64'd0);
    check_output("rst_value_out", value_out, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      $display("[TB] vector %0d op=%s", i, vecs[i].op.name());
      apply_stimulus(vecs[i]);
    end

    // Back-pressure: response held across a 5-cycle stall while a new request waits
    $display("[TB] response stall sequence");
    v = '{READ, 32'h21, 64'h0, 1, 1, 1, 1, 1, 64'hABCD, 1, 64'hABCD, 0, 0, 1};
    do_accept(v.op, v.key, v.value);
    run_wait(v, waits);
    check_resp(v);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = UPSERT; req_key = 32'h33; req_value = 64'h44;
      @(negedge clk);
      check_output("stall_resp_valid", 64'(resp_valid), 64'd1);
      check_output("stall_resp_value", resp_value, 64'hABCD);
      check_output("stall_resp_hit", 64'(resp_hit), 64'd1);
      check_output("stall_req_ready", 64'(req_ready), 64'd0);
      check_output("stall_key_hold", 64'(key_out), 64'h21);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("hs_req_ready", 64'(req_ready), 64'd1);
    check_output("hs_not_accepted", 64'(key_out), 64'h21);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("late_accept_op", 64'(operation_out), 64'(UPSERT));
    check_output("late_accept_key", 64'(key_out), 64'h33);
    @(negedge clk);
    v = '{UPSERT, 32'h33, 64'h44, 1, 1, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0, 1};
    run_wait(v, waits);
    check_output("late_wait_cycles", 64'(waits), 64'd1);
    check_resp(v);
    handshake();

    // Asynchronous reset in the middle of WAIT discards the request
    $display("[TB] reset during WAIT sequence");
    do_accept(READ, 32'h40, 64'h99);
    busy_valid_in = 1'b1; busy_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check_output("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check_output("mid_rst_op", 64'(operation_out), 64'(NOOP));
    check_output("mid_rst_key_out", 64'(key_out), 64'd0);
    check_output("mid_rst_value_out", value_out, 64'd0);
    check_output("mid_rst_resp_err", 64'(resp_err), 64'd0);
    clear_ctrl();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    apply_stimulus(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
